csr_file: RTL and testbench

Machine-mode CSR file for the AdamRiscv core: the next generation of the writeback-stage CSR block. It adds:

- parametrised XLEN, reset vector and hart ID;
- full CSRRW/CSRRS/CSRRC read-modify-write semantics;
- mie/mip/mscratch/misa/mhartid;
- 64-bit mcycle/minstret counters;
- internal interrupt arbitration with vectored mtvec.

It sits in WB, is written at commit, and supplies trap/return targets to the PC-select logic.

---
 rtl/csr_file_pkg.sv | 51 +++++
 rtl/csr_counter64.sv | 26 ++
 rtl/csr_file.sv | 251 +++++++++++++++++++++++++
 tb/tb_csr_file.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: addresses, csr_op encodings, interrupt cause codes, misa value.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package csr_file_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // csr_op encodings
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Interrupt cause codes; they double as the mip/mie bit positions
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // RV32I: MXL=1, extension bit I
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // Writable bits of mie
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    // Address decode for every CSR this file responds to. The counter
    // addresses always decode so software sees them as legal even when
    // the counters are compiled out.
    function automatic logic csr_implemented(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
                            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
                            CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
                            CSR_MINSTRETH, CSR_MHARTID};
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment and independent write of each 32-bit half.
// Latency: writes and increments land on the next clk edge.
// Backpressure: none; a write to either half suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Software write wins over counting; the untouched half is preserved
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap/mret stacking, interrupt arbitration, counters under CSR_COUNTERS_EN.
// Latency: rdata_o/illegal_o/irq_req_o/trap_vec_o combinational; writes and trap updates visible next cycle.
// Backpressure: none; every commit-stage event is accepted in the cycle it is presented.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     raddr_i,
    output logic [XLEN-1:0] rdata_o,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     waddr_i,
    input  logic [XLEN-1:0] wsrc_i,
    output logic            illegal_o,
    input  logic            exc_i,
    input  logic [3:0]      exc_code_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            irq_sw_i,
    output logic            irq_req_o,
    input  logic            irq_ack_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            mret_i,
    input  logic            instret_i,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o
);

    csr_op_e         op;
    logic            op_active;
    logic            op_writes;
    logic            csr_we;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] new_view;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] mip_next;
    logic [XLEN-1:0] trap_base;
    logic [3:0]      irq_code;

    logic            mst_mie;
    logic            mst_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mip_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    assign op     = csr_op_e'(csr_op_i);
    assign mepc_o = mepc_q;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic        cyc_wr_lo;
    logic        cyc_wr_hi;
    logic        ins_wr_lo;
    logic        ins_wr_hi;

    assign cyc_wr_lo = csr_we && (waddr_i == CSR_MCYCLE);
    assign cyc_wr_hi = csr_we && (waddr_i == CSR_MCYCLEH);
    assign ins_wr_lo = csr_we && (waddr_i == CSR_MINSTRET);
    assign ins_wr_hi = csr_we && (waddr_i == CSR_MINSTRETH);

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (new_val),
        .count (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instret_i),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (new_val),
        .count (minstret_q)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_i;
`endif

    // Architectural read view of one CSR
    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
        logic [XLEN-1:0] v;
        v = '0;
        case (addr)
            CSR_MSTATUS:   v = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
            CSR_MISA:      v = MISA_VALUE;
            CSR_MIE:       v = mie_q;
            CSR_MTVEC:     v = mtvec_q;
            CSR_MSCRATCH:  v = mscratch_q;
            CSR_MEPC:      v = mepc_q;
            CSR_MCAUSE:    v = mcause_q;
            CSR_MTVAL:     v = mtval_q;
            CSR_MIP:       v = mip_q;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    v = mcycle_q[31:0];
            CSR_MCYCLEH:   v = mcycle_q[63:32];
            CSR_MINSTRET:  v = minstret_q[31:0];
            CSR_MINSTRETH: v = minstret_q[63:32];
`endif
            CSR_MHARTID:   v = HART_ID;
            default:       v = '0;
        endcase
        return v;
    endfunction

    // CSRs whose storage software can change (misa/mip/mhartid cannot)
    function automatic logic csr_writable(input logic [11:0] addr);
`ifdef CSR_COUNTERS_EN
        return addr inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
                            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE,
                            CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH};
`else
        return addr inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
                            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};
`endif
    endfunction

    // What a CSR will read back as after being written with v (field masking)
    function automatic logic [XLEN-1:0] csr_write_view(input logic [11:0] addr,
                                                       input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        case (addr)
            CSR_MSTATUS: r = {19'b0, 2'b11, 3'b0, v[7], 3'b0, v[3], 3'b0};
            CSR_MIE:     r = v & MIE_MASK;
            CSR_MTVEC:   r = {v[XLEN-1:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
            CSR_MEPC:    r = {v[XLEN-1:2], 2'b00};
            default:     r = v;
        endcase
        return r;
    endfunction

    // Decode the access, compute the read-modify-write value and the write enable
    always_comb begin
        op_active = (op != CSR_OP_NONE);
        op_writes = (op == CSR_OP_RW) || (wsrc_i != '0);
        illegal_o = op_active &&
                    (!csr_implemented(waddr_i) ||
                     ((waddr_i[11:10] == 2'b11) && op_writes));
        old_val   = csr_read(waddr_i);
        case (op)
            CSR_OP_RW: new_val = wsrc_i;
            CSR_OP_RS: new_val = old_val | wsrc_i;
            CSR_OP_RC: new_val = old_val & ~wsrc_i;
            default:   new_val = old_val;
        endcase
        new_view  = csr_write_view(waddr_i, new_val);
        // Trap, interrupt and mret all take precedence and drop the write
        csr_we    = op_active && op_writes && !illegal_o && csr_writable(waddr_i) &&
                    !exc_i && !irq_ack_i && !mret_i;
    end

    // Read port with same-cycle write bypass; illegal accesses read zero
    always_comb begin
        if (illegal_o) begin
            rdata_o = '0;
        end else if (op_active && (waddr_i == raddr_i) && csr_writable(waddr_i)) begin
            rdata_o = new_view;
        end else begin
            rdata_o = csr_read(raddr_i);
        end
    end

    // Interrupt arbitration (MEI > MSI > MTI) and trap target selection
    always_comb begin
        pend = mip_q & mie_q;
        if (pend[IRQ_CODE_MEI])      irq_code = IRQ_CODE_MEI;
        else if (pend[IRQ_CODE_MSI]) irq_code = IRQ_CODE_MSI;
        else if (pend[IRQ_CODE_MTI]) irq_code = IRQ_CODE_MTI;
        else                         irq_code = 4'd0;
        irq_req_o  = mst_mie && (pend != '0);
        trap_base  = {mtvec_q[XLEN-1:2], 2'b00};
        trap_vec_o = trap_base;
        if ((mtvec_q[1:0] == 2'b01) && irq_req_o && !exc_i) begin
            trap_vec_o = trap_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
        end
    end

    // Pending bits as they will be latched into mip
    always_comb begin
        mip_next               = '0;
        mip_next[IRQ_CODE_MEI] = irq_ext_i;
        mip_next[IRQ_CODE_MTI] = irq_timer_i;
        mip_next[IRQ_CODE_MSI] = irq_sw_i;
    end

    // CSR state: traps first, then mret, then software writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mip_q <= mip_next;
            if (exc_i) begin
                mepc_q   <= exc_pc_i;
                mcause_q <= {{(XLEN-4){1'b0}}, exc_code_i};
                mtval_q  <= exc_tval_i;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (irq_ack_i) begin
                mepc_q   <= irq_pc_i;
                mcause_q <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                mtval_q  <= '0;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_i) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (csr_we) begin
                case (waddr_i)
                    CSR_MSTATUS: begin
                        mst_mie  <= new_val[3];
                        mst_mpie <= new_val[7];
                    end
                    CSR_MIE:      mie_q      <= new_view;
                    CSR_MTVEC:    mtvec_q    <= new_view;
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    CSR_MEPC:     mepc_q     <= new_view;
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    CSR_MTVAL:    mtval_q    <= new_val;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed plan steps followed by random traffic against a behavioural model.
// Latency: outputs sampled 2 ns after the rising edge; model advanced once per edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_csr_file;

    localparam logic [31:0] HART     = 32'd5;
    localparam logic [31:0] TVEC_RST = 32'h0000_0100;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] raddr_i, waddr_i;
    logic [31:0] rdata_o, wsrc_i;
    logic [1:0]  csr_op_i;
    logic        illegal_o, exc_i;
    logic [3:0]  exc_code_i;
    logic [31:0] exc_pc_i, exc_tval_i, irq_pc_i, trap_vec_o, mepc_o;
    logic        irq_ext_i, irq_timer_i, irq_sw_i, irq_req_o, irq_ack_i;
    logic        mret_i, instret_i;

    csr_file #(.XLEN(32), .MTVEC_RESET(TVEC_RST), .HART_ID(HART)) dut (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .csr_op_i(csr_op_i), .waddr_i(waddr_i), .wsrc_i(wsrc_i), .illegal_o(illegal_o),
        .exc_i(exc_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
        .irq_req_o(irq_req_o), .irq_ack_i(irq_ack_i), .irq_pc_i(irq_pc_i),
        .mret_i(mret_i), .instret_i(instret_i), .trap_vec_o(trap_vec_o), .mepc_o(mepc_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state, kept as named architectural fields
    logic [31:0] m_scr, m_epc, m_cause, m_tval, m_tvec, m_ie;
    logic        m_mie, m_mpie;
    logic [2:0]  m_irq;   // {ext, timer, sw} as last latched
    logic [63:0] m_cyc, m_ins;

    task automatic m_reset();
        m_scr = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_ie = 0;
        m_tvec = TVEC_RST; m_mie = 0; m_mpie = 0; m_irq = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [31:0] m_mip();
        return {20'b0, m_irq[2], 3'b0, m_irq[1], 3'b0, m_irq[0], 3'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {19'b0, 2'b11, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h301: return 32'h4000_0100;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_mip();
            12'hB00: return CNT_EN ? m_cyc[31:0]  : 32'h0;
            12'hB80: return CNT_EN ? m_cyc[63:32] : 32'h0;
            12'hB02: return CNT_EN ? m_ins[31:0]  : 32'h0;
            12'hB82: return CNT_EN ? m_ins[63:32] : 32'h0;
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343}) ||
               (CNT_EN && (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82}));
    endfunction

    function automatic bit m_is_write();
        return (csr_op_i == 2'b01) || (wsrc_i != 32'h0);
    endfunction

    function automatic bit m_illegal();
        return (csr_op_i != 2'b00) &&
               (!m_impl(waddr_i) || ((waddr_i[11:10] == 2'b11) && m_is_write()));
    endfunction

    function automatic logic [31:0] m_nv();
        logic [31:0] old;
        old = m_read(waddr_i);
        case (csr_op_i)
            2'b01:   return wsrc_i;
            2'b10:   return old | wsrc_i;
            2'b11:   return old & ~wsrc_i;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] m_view(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: return {19'b0, 2'b11, 3'b0, v[7], 3'b0, v[3], 3'b0};
            12'h304: return v & 32'h888;
            12'h305: return {v[31:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
            12'h341: return {v[31:2], 2'b00};
            default: return v;
        endcase
    endfunction

    // Highest-priority enabled pending interrupt, walking the priority list
    function automatic logic [3:0] m_code();
        int order [3];
        logic [31:0] p;
        order = '{11, 3, 7};
        p = m_mip() & m_ie;
        for (int i = 0; i < 3; i++) if (p[order[i]]) return 4'(order[i]);
        return 4'd0;
    endfunction

    function automatic bit m_irq_req();
        return m_mie && ((m_mip() & m_ie) != 32'h0);
    endfunction

    function automatic logic [31:0] exp_trap();
        logic [31:0] base;
        base = {m_tvec[31:2], 2'b00};
        if (m_tvec[1:0] == 2'b01 && m_irq_req() && !exc_i) return base + 32'(m_code()) * 4;
        return base;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_illegal()) return 32'h0;
        if (csr_op_i != 2'b00 && waddr_i == raddr_i && m_writable(waddr_i))
            return m_view(waddr_i, m_nv());
        return m_read(raddr_i);
    endfunction

    // Advance the model across one rising edge using the inputs presented
    task automatic m_clock();
        logic [31:0] nv;
        logic [3:0]  code;
        bit          wr;
        if (!rst_n) begin
            m_reset();
        end else begin
            nv   = m_nv();
            code = m_code();
            wr   = (csr_op_i != 2'b00) && !m_illegal() && m_is_write() && m_writable(waddr_i) &&
                   !exc_i && !irq_ack_i && !mret_i;
            if (wr && waddr_i == 12'hB00)      m_cyc[31:0]  = nv;
            else if (wr && waddr_i == 12'hB80) m_cyc[63:32] = nv;
            else                               m_cyc        = m_cyc + 64'd1;
            if (wr && waddr_i == 12'hB02)      m_ins[31:0]  = nv;
            else if (wr && waddr_i == 12'hB82) m_ins[63:32] = nv;
            else if (instret_i)                m_ins        = m_ins + 64'd1;
            if (exc_i) begin
                m_epc = exc_pc_i; m_cause = {28'b0, exc_code_i}; m_tval = exc_tval_i;
                m_mpie = m_mie; m_mie = 1'b0;
            end else if (irq_ack_i) begin
                m_epc = irq_pc_i; m_cause = 32'h8000_0000 | 32'(code); m_tval = 0;
                m_mpie = m_mie; m_mie = 1'b0;
            end else if (mret_i) begin
                m_mie = m_mpie; m_mpie = 1'b1;
            end else if (wr) begin
                case (waddr_i)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_ie   = m_view(12'h304, nv);
                    12'h305: m_tvec = m_view(12'h305, nv);
                    12'h340: m_scr  = nv;
                    12'h341: m_epc  = m_view(12'h341, nv);
                    12'h342: m_cause = nv;
                    12'h343: m_tval = nv;
                    default: ;
                endcase
            end
            m_irq = {irq_ext_i, irq_timer_i, irq_sw_i};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("rdata", rdata_o, exp_rdata());
        chk("illegal", {31'b0, illegal_o}, {31'b0, m_illegal()});
        chk("irq_req", {31'b0, irq_req_o}, {31'b0, m_irq_req()});
        chk("trap_vec", trap_vec_o, exp_trap());
        chk("mepc_o", mepc_o, m_epc);
    endtask

    task automatic idle();
        csr_op_i = 0; waddr_i = 0; raddr_i = 0; wsrc_i = 0; exc_i = 0; exc_code_i = 0;
        exc_pc_i = 0; exc_tval_i = 0; irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
        irq_ack_i = 0; irq_pc_i = 0; mret_i = 0; instret_i = 0;
    endtask

    task automatic tick(input bit do_chk);
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        raddr_i = a; csr_op_i = 2'b00;
        #1;
        chk(tag, rdata_o, exp);
        check_all();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] w,
                      output logic [31:0] rd_seen, output logic ill_seen);
        csr_op_i = o; waddr_i = a; raddr_i = a; wsrc_i = w;
        #1;
        rd_seen  = rdata_o;
        ill_seen = illegal_o;
        check_all();
        @(posedge clk);
        m_clock();
        #1;
        csr_op_i = 2'b00; wsrc_i = 0;
    endtask

    logic [31:0] seen;
    logic        ill;
    logic [11:0] addrs [15];

    initial begin
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0};
        idle();
        rst_n = 1'b0;
        m_reset();
        tick(1'b0);
        tick(1'b1);
        rst_n = 1'b1;

        // Reset state
        rd(12'h305, TVEC_RST, "rst_mtvec");
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'hF14, HART, "rst_mhartid");
        rd(12'h301, 32'h4000_0100, "rst_misa");
        rd(12'h340, 32'h0, "rst_mscratch");
        chk("rst_irq_req", {31'b0, irq_req_o}, 32'h0);

        // Read-modify-write on mscratch
        op(2'b01, 12'h340, 32'h100, seen, ill);
        op(2'b10, 12'h340, 32'h0F0, seen, ill);
        chk("rs_bypass", seen, 32'h1F0);
        rd(12'h340, 32'h1F0, "rs_mscratch");
        op(2'b11, 12'h340, 32'h010, seen, ill);
        rd(12'h340, 32'h1E0, "rc_mscratch");
        op(2'b10, 12'h340, 32'h0, seen, ill);
        rd(12'h340, 32'h1E0, "rs0_mscratch");

        // Exception then mret
        op(2'b10, 12'h300, 32'h8, seen, ill);
        exc_i = 1; exc_code_i = 4'd2; exc_pc_i = 32'h80; exc_tval_i = 32'hDEAD;
        tick(1'b1);
        exc_i = 0;
        rd(12'h341, 32'h80, "exc_mepc");
        rd(12'h342, 32'h2, "exc_mcause");
        rd(12'h343, 32'hDEAD, "exc_mtval");
        rd(12'h300, 32'h0000_1880, "exc_mstatus");
        mret_i = 1;
        tick(1'b1);
        mret_i = 0;
        rd(12'h300, 32'h0000_1888, "mret_mstatus");

        // Vectored interrupt
        op(2'b01, 12'h305, 32'h1001, seen, ill);
        op(2'b01, 12'h304, 32'h880, seen, ill);
        irq_timer_i = 1; irq_ext_i = 1;
        #1;
        chk("irq_req_lag", {31'b0, irq_req_o}, 32'h0);
        check_all();
        @(posedge clk); m_clock(); #1;
        #1;
        chk("irq_req_set", {31'b0, irq_req_o}, 32'h1);
        chk("trap_vec_vect", trap_vec_o, 32'h102C);
        irq_ack_i = 1; irq_pc_i = 32'h200;
        check_all();
        @(posedge clk); m_clock(); #1;
        irq_ack_i = 0;
        rd(12'h342, 32'h8000_000B, "irq_mcause");
        rd(12'h341, 32'h200, "irq_mepc");
        chk("irq_req_masked", {31'b0, irq_req_o}, 32'h0);
        irq_timer_i = 0; irq_ext_i = 0;
        tick(1'b1);

        // Exception wins over a simultaneous CSR write
        exc_i = 1; exc_code_i = 4'd5; exc_pc_i = 32'h44; exc_tval_i = 32'h7;
        op(2'b01, 12'h340, 32'hABC, seen, ill);
        exc_i = 0;
        rd(12'h340, 32'h1E0, "exc_drops_write");
        rd(12'h342, 32'h5, "exc_wr_mcause");

`ifdef CSR_COUNTERS_EN
        // 64-bit carry across the halves
        op(2'b01, 12'hB00, 32'hFFFF_FFFF, seen, ill);
        op(2'b01, 12'hB80, 32'h0, seen, ill);
        tick(1'b1);
        raddr_i = 12'hB80; #1;
        chk("mcycleh_carry", rdata_o, 32'h1);
        raddr_i = 12'hB00; #1;
        chk("mcycle_wrap", rdata_o, 32'h0);
        check_all();
        @(posedge clk); m_clock(); #1;
`else
        op(2'b01, 12'hB00, 32'hDEAD_BEEF, seen, ill);
        chk("cnt_off_legal", {31'b0, ill}, 32'h0);
        rd(12'hB00, 32'h0, "cnt_off_read");
`endif

        // Illegal accesses and ignored read-only writes
        op(2'b01, 12'hF14, 32'h123, seen, ill);
        chk("ill_hartid", {31'b0, ill}, 32'h1);
        chk("ill_hartid_rd", seen, 32'h0);
        rd(12'hF14, HART, "hartid_kept");
        op(2'b10, 12'h7C0, 32'h0, seen, ill);
        chk("ill_unimpl", {31'b0, ill}, 32'h1);
        chk("ill_unimpl_rd", seen, 32'h0);
        op(2'b01, 12'h301, 32'h0, seen, ill);
        chk("misa_wr_legal", {31'b0, ill}, 32'h0);
        rd(12'h301, 32'h4000_0100, "misa_kept");
        op(2'b01, 12'h344, 32'hFFFF, seen, ill);
        chk("mip_wr_legal", {31'b0, ill}, 32'h0);

        // Field masking on write
        op(2'b01, 12'h305, 32'h2003, seen, ill);
        rd(12'h305, 32'h2000, "mtvec_mode1x");
        op(2'b01, 12'h341, 32'h1237, seen, ill);
        rd(12'h341, 32'h1234, "mepc_align");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            csr_op_i    = 2'($urandom_range(0, 3));
            waddr_i     = addrs[$urandom_range(0, 14)];
            raddr_i     = ($urandom_range(0, 2) == 0) ? addrs[$urandom_range(0, 14)] : waddr_i;
            wsrc_i      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            exc_i       = ($urandom_range(0, 15) == 0);
            exc_code_i  = 4'($urandom_range(0, 15));
            exc_pc_i    = $urandom;
            exc_tval_i  = $urandom;
            if ($urandom_range(0, 3) == 0) irq_ext_i   = ~irq_ext_i;
            if ($urandom_range(0, 3) == 0) irq_timer_i = ~irq_timer_i;
            if ($urandom_range(0, 3) == 0) irq_sw_i    = ~irq_sw_i;
            irq_ack_i   = ($urandom_range(0, 11) == 0);
            irq_pc_i    = $urandom;
            mret_i      = ($urandom_range(0, 9) == 0);
            instret_i   = 1'($urandom_range(0, 1));
            tick(1'b1);
        end

        // Reset asserted during a trap discards the update
        idle();
        exc_i = 1; exc_code_i = 4'd7; exc_pc_i = 32'h444; rst_n = 1'b0;
        tick(1'b1);
        exc_i = 0; rst_n = 1'b1;
        rd(12'h341, 32'h0, "rst_mid_trap_mepc");
        rd(12'h342, 32'h0, "rst_mid_trap_mcause");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
